// File: rtl/mat_vec_mult_sys_pkg.sv
// Shared types and sizing helpers for the skewed matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Accumulator width that cannot overflow for COLS products of two operands.
  function automatic int acc_width(input int data_width, input int cols);
    return 2 * data_width + $clog2(cols);
  endfunction

  // Width of the compute-phase counter, which spans 0..ROWS+COLS-1.
  function automatic int phase_width(input int rows, input int cols);
    return (rows + cols > 1) ? $clog2(rows + cols) : 1;
  endfunction

endpackage

// File: rtl/mat_vec_mult_sys_if.sv
// Host-side bus of the matrix-vector multiplier: load, control and result signals.
interface mat_vec_mult_sys_if
  import mvm_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, COLS)
);
  logic                                a_wren;
  logic [ROWS-1:0][DATA_WIDTH-1:0]     a_data;
  logic                                b_wren;
  logic [DATA_WIDTH-1:0]               b_data;
  logic                                start;
  logic                                clr;
  logic                                a_full;
  logic                                b_full;
  logic                                busy;
  logic                                done;
  logic                                err;
  logic [ROWS-1:0][ACC_WIDTH-1:0]      out;

  modport master (
    output a_wren, a_data, b_wren, b_data, start, clr,
    input  a_full, b_full, busy, done, err, out
  );

  modport slave (
    input  a_wren, a_data, b_wren, b_data, start, clr,
    output a_full, b_full, busy, done, err, out
  );
endinterface

// File: rtl/mat_vec_mult_sys_mac_lane.sv
// One multiply-accumulate lane (one matrix row).
// Build option MVM_SIGNED_EN: treat operands as two's complement and
// sign-extend products; otherwise operands are unsigned and zero-extended.
module mvm_mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_zero,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc
);
  logic [ACC_WIDTH-1:0] r_acc;

  function automatic logic [ACC_WIDTH-1:0] ext_prod(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
`ifdef MVM_SIGNED_EN
    logic signed [2*DATA_WIDTH-1:0] p;
    p = $signed(a) * $signed(b);
    return ACC_WIDTH'(p);
`else
    logic [2*DATA_WIDTH-1:0] p;
    p = a * b;
    return ACC_WIDTH'(p);
`endif
  endfunction

  // Accumulate modulo 2^ACC_WIDTH; zero has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_acc <= '0;
    else if (i_zero) r_acc <= '0;
    else if (i_en)   r_acc <= r_acc + ext_prod(i_a, i_b);
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/mvm_fifo.sv
// Single-clock FIFO with registered read data (1-cycle read latency).
// Writes while full and reads while empty are dropped internally.
module mvm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_last
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_last  = (r_count == CW'(DEPTH - 1));
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & (r_count != '0);
  assign o_rdata = r_rdata;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage and registered read port.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
    if (w_rd) r_rdata <= r_mem[r_rptr];
  end
endmodule

// File: rtl/mat_vec_mult_sys.sv
// Skewed matrix-vector multiplier: ROWS x COLS matrix (loaded column by column
// into per-row FIFOs) times a COLS vector. Compute lasts ROWS+COLS cycles.
// Build option MVM_SIGNED_EN selects two's-complement arithmetic in the lanes.
module mat_vec_mult_sys
  import mvm_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, COLS)
) (
  input logic                clk,
  input logic                rst_n,
  mat_vec_mult_sys_if.slave  bus
);
  localparam int            PW   = phase_width(ROWS, COLS);
  localparam logic [PW-1:0] LAST = PW'(ROWS + COLS - 1);

  state_e                r_state, w_state_nxt;
  logic [PW-1:0]         r_phase;
  logic                  r_err;
  logic                  w_load_ok, w_a_wr, w_b_wr, w_a_full, w_b_full;
  logic                  w_a_ready, w_b_ready, w_start_ok, w_start_bad, w_clr_ok;
  logic                  w_new_err, w_acc_zero, w_compute, w_b_rd, w_b_last;
  logic [ROWS-1:0]       w_a_full_row, w_a_last_row, w_a_rd, w_lane_en;
  logic [DATA_WIDTH-1:0] w_a_rdata [ROWS];
  logic [DATA_WIDTH-1:0] w_b_lane  [ROWS];
  logic [DATA_WIDTH-1:0] w_b_rdata;
  logic [ACC_WIDTH-1:0]  w_acc     [ROWS];

  assign w_compute = (r_state == COMPUTE);
  assign w_load_ok = ~w_compute;
  assign w_a_wr    = bus.a_wren & w_load_ok;
  assign w_b_wr    = bus.b_wren & w_load_ok;
  assign w_a_full  = &w_a_full_row;
  // A write in the start cycle counts as already landed.
  assign w_a_ready = w_a_full | (w_a_wr & (&w_a_last_row));
  assign w_b_ready = w_b_full | (w_b_wr & w_b_last);
  assign w_start_ok  = bus.start & w_load_ok & w_a_ready & w_b_ready;
  assign w_start_bad = bus.start & w_load_ok & ~(w_a_ready & w_b_ready);
  assign w_clr_ok    = bus.clr & w_load_ok;
  assign w_new_err   = (w_a_wr & w_a_full) | (w_b_wr & w_b_full) | w_start_bad;
  assign w_b_rd      = w_compute & (r_phase <= PW'(COLS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; accumulators are zeroed on an accepted start or clear.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_zero  = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_start_ok) begin
          w_state_nxt = COMPUTE;
          w_acc_zero  = 1'b1;
        end else if (w_clr_ok) begin
          w_state_nxt = IDLE;
          w_acc_zero  = 1'b1;
        end
      end
      COMPUTE: if (r_phase == LAST) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Compute-phase counter: cycle 0 is the first COMPUTE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_phase <= '0;
    else if (w_start_ok) r_phase <= '0;
    else if (w_compute)  r_phase <= r_phase + 1'b1;
  end

  // Sticky error flag; clear drops history but a same-cycle error still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_clr_ok) r_err <= w_new_err;
    else               r_err <= r_err | w_new_err;
  end

  mvm_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_b_fifo (
    .clk(clk), .rst_n(rst_n), .i_wr(w_b_wr), .i_wdata(bus.b_data), .i_rd(w_b_rd),
    .o_rdata(w_b_rdata), .o_full(w_b_full), .o_last(w_b_last)
  );

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    // Row i reads on cycles i..i+COLS-1 and accumulates one cycle later.
    if (i == 0) begin : g_rd0
      assign w_a_rd[i] = w_compute & (r_phase <= PW'(COLS - 1));
      assign w_b_lane[i] = w_b_rdata;
    end else begin : g_rdn
      logic [DATA_WIDTH-1:0] r_b_skew;
      assign w_a_rd[i] = w_compute & (r_phase >= PW'(i)) & (r_phase <= PW'(i + COLS - 1));
      // One skew stage per row delays b[k] to meet a[i][k].
      always_ff @(posedge clk) r_b_skew <= w_b_lane[i-1];
      assign w_b_lane[i] = r_b_skew;
    end

    assign w_lane_en[i] = w_compute & (r_phase >= PW'(i + 1)) & (r_phase <= PW'(i + COLS));

    mvm_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_a_fifo (
      .clk(clk), .rst_n(rst_n), .i_wr(w_a_wr), .i_wdata(bus.a_data[i]), .i_rd(w_a_rd[i]),
      .o_rdata(w_a_rdata[i]), .o_full(w_a_full_row[i]), .o_last(w_a_last_row[i])
    );

    mvm_mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
      .clk(clk), .rst_n(rst_n), .i_en(w_lane_en[i]), .i_zero(w_acc_zero),
      .i_a(w_a_rdata[i]), .i_b(w_b_lane[i]), .o_acc(w_acc[i])
    );

    assign bus.out[i] = w_acc[i];
  end

  assign bus.a_full = w_a_full;
  assign bus.b_full = w_b_full;
  assign bus.busy   = w_compute;
  assign bus.done   = (r_state == DONE);
  assign bus.err    = r_err;
endmodule

// File: tb/tb_mat_vec_mult_sys.sv
// Directed bench for mat_vec_mult_sys (8x8, 8-bit operands, 19-bit results).
module tb_mat_vec_mult_sys;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int AW   = 19;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mat_vec_mult_sys_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  mat_vec_mult_sys #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [DW-1:0] ma [ROWS][COLS];
  logic [DW-1:0] vb [COLS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write columns 0..na-1 of ma and elements 0..nb-1 of vb, in parallel.
  task automatic load(input int na, input int nb);
    for (int k = 0; k < COLS; k++) begin
      if (k < na) begin
        bus.a_wren = 1'b1;
        for (int i = 0; i < ROWS; i++) bus.a_data[i] = ma[i][k];
      end
      if (k < nb) begin
        bus.b_wren = 1'b1;
        bus.b_data = vb[k];
      end
      if (k < na || k < nb) tick();
      bus.a_wren = 1'b0;
      bus.b_wren = 1'b0;
    end
  endtask

  // Pulse start (optionally with the last b element in the same cycle), then
  // wait for done; lat counts edges from the start edge (inclusive).
  task automatic run(input bit last_b_with_start, input bit disturb, output int lat);
    bus.start = 1'b1;
    if (last_b_with_start) begin
      bus.b_wren = 1'b1;
      bus.b_data = vb[COLS-1];
    end
    tick();
    bus.start  = 1'b0;
    bus.b_wren = 1'b0;
    lat = 1;
    chk("busy_after_start", bus.busy, 1);
    chk("done_after_start", bus.done, 0);
    while (!bus.done && lat < 40) begin
      if (disturb && lat == 3) begin
        bus.start  = 1'b1;
        bus.b_wren = 1'b1;
        bus.b_data = 8'hAA;
      end
      tick();
      lat++;
      bus.start  = 1'b0;
      bus.b_wren = 1'b0;
    end
    chk("latency", lat, 17);
    chk("busy_at_done", bus.busy, 0);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  int lat;

  initial begin
    bus.a_wren = 1'b0;
    bus.b_wren = 1'b0;
    bus.start  = 1'b0;
    bus.clr    = 1'b0;
    bus.b_data = '0;
    for (int i = 0; i < ROWS; i++) bus.a_data[i] = '0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_a_full", bus.a_full, 0);
    chk("rst_b_full", bus.b_full, 0);
    chk("rst_out0", bus.out[0], 0);
    chk("rst_out7", bus.out[7], 0);
    rst_n = 1'b1;
    tick();

    // Basic: a[i][k]=i+1, b[k]=k+1 -> out[i]=(i+1)*36.
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < COLS; k++) ma[i][k] = DW'(i + 1);
    for (int k = 0; k < COLS; k++) vb[k] = DW'(k + 1);
    load(COLS, COLS);
    chk("basic_a_full", bus.a_full, 1);
    chk("basic_b_full", bus.b_full, 1);
    run(1'b0, 1'b0, lat);
    for (int i = 0; i < ROWS; i++) chk($sformatf("basic_out%0d", i), bus.out[i], 32'((i + 1) * 36));
    chk("basic_err", bus.err, 0);
    chk("basic_a_empty", bus.a_full, 0);

    // Back-to-back: reload in DONE (results held), a[i][k]=k, b=1 -> 28.
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < COLS; k++) ma[i][k] = DW'(k);
    for (int k = 0; k < COLS; k++) vb[k] = 8'd1;
    load(COLS, COLS);
    chk("b2b_held_out3", bus.out[3], 144);
    chk("b2b_held_done", bus.done, 1);
    run(1'b0, 1'b0, lat);
    chk("b2b_out0", bus.out[0], 28);
    chk("b2b_out7", bus.out[7], 28);

    // Clear from DONE.
    pulse_clr();
    chk("clr_out0", bus.out[0], 0);
    chk("clr_done", bus.done, 0);

    // Max operands.
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < COLS; k++) ma[i][k] = 8'hFF;
    for (int k = 0; k < COLS; k++) vb[k] = 8'hFF;
    load(COLS, COLS);
    run(1'b0, 1'b0, lat);
`ifdef MVM_SIGNED_EN
    chk("max_out0", bus.out[0], 8);
    chk("max_out7", bus.out[7], 8);
`else
    chk("max_out0", bus.out[0], 520200);
    chk("max_out7", bus.out[7], 520200);
`endif
    chk("max_err", bus.err, 0);

    // a=0xFF, b=2: -16 signed, 4080 unsigned.
    for (int k = 0; k < COLS; k++) vb[k] = 8'd2;
    load(COLS, COLS);
    run(1'b0, 1'b0, lat);
`ifdef MVM_SIGNED_EN
    chk("sgn_out0", bus.out[0], 32'h7FFF0);
    chk("sgn_out5", bus.out[5], 32'h7FFF0);
`else
    chk("sgn_out0", bus.out[0], 4080);
    chk("sgn_out5", bus.out[5], 4080);
`endif

    // Protocol errors: start with 7 b elements, 9th a column, clears.
    pulse_clr();
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < COLS; k++) ma[i][k] = 8'd1;
    for (int k = 0; k < COLS; k++) vb[k] = DW'(k + 1);
    load(COLS, COLS - 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("short_start_busy", bus.busy, 0);
    chk("short_start_err", bus.err, 1);
    chk("short_b_full", bus.b_full, 0);
    pulse_clr();
    chk("clr_err", bus.err, 0);
    bus.a_wren = 1'b1;
    for (int i = 0; i < ROWS; i++) bus.a_data[i] = 8'd100;
    tick();
    bus.a_wren = 1'b0;
    chk("overflow_err", bus.err, 1);
    chk("overflow_a_full", bus.a_full, 1);
    pulse_clr();
    chk("clr_err2", bus.err, 0);
    // Last b element together with start; start and write injected mid-compute.
    run(1'b1, 1'b1, lat);
    chk("wrstart_out0", bus.out[0], 36);
    chk("wrstart_out7", bus.out[7], 36);
    chk("wrstart_err", bus.err, 0);
    chk("wrstart_b_empty", bus.b_full, 0);

    // Reset at COMPUTE cycle 5.
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < COLS; k++) ma[i][k] = DW'(i + 1);
    for (int k = 0; k < COLS; k++) vb[k] = DW'(k + 1);
    load(COLS, COLS);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_out0", bus.out[0], 0);
    chk("mid_rst_a_full", bus.a_full, 0);
    chk("mid_rst_b_full", bus.b_full, 0);
    tick();
    rst_n = 1'b1;
    tick();
    load(COLS, COLS);
    run(1'b0, 1'b0, lat);
    chk("post_rst_out0", bus.out[0], 36);
    chk("post_rst_out7", bus.out[7], 288);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
